// File: rtl/if_pc_sequencer.sv
// ----------------------------------------------------------------------------
// if_pc_sequencer
//
// Purpose: owns the architectural fetch PC. Each cycle it picks the next
// fetch address from three sources: sequential PC+4, the branch target or
// the jump target from the ID stage. It also squashes the wrong-path word
// entering IF/ID. A redirect that arrives while instruction memory is
// waiting is parked in a pending register, so it cannot be lost.
//
// Handshake: a fetch "completes" on a cycle where Imem_Ready_IF=1 and
// Stall_IF=0 (advance). A redirect is "accepted" on a cycle where
// Branch_Taken_ID or Jump_ID is high and Stall_IF=0. While Stall_IF=1 the
// ID stage holds its request and presents it again, so nothing is dropped.
//
// Ports:
//   Clk, Rst_n        clock (rising edge) and async active-low reset
//   Stall_IF          hazard hold: PC, state and pending target freeze
//   Imem_Ready_IF     memory returns the word at PC_IF this cycle
//   Branch_Taken_ID   taken branch in ID (wins over a jump)
//   Branch_Dest_ID    branch target
//   Jump_ID           jump in ID
//   Jump_Dest_ID      jump target
//   PC_IF             registered fetch address
//   PC_Plus_4_IF      PC_IF + 4 (wraps modulo 2^32)
//   Fetch_Valid_IF    word at PC_IF is on the correct path
//   Flush_IF_ID       IF/ID loads a bubble at the next edge
//   Redirect_Pending  FSM is in PEND (state visibility for debug/perf)
// ----------------------------------------------------------------------------
module if_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall_IF,
    input  logic        Imem_Ready_IF,
    input  logic        Branch_Taken_ID,
    input  logic [31:0] Branch_Dest_ID,
    input  logic        Jump_ID,
    input  logic [31:0] Jump_Dest_ID,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_Plus_4_IF,
    output logic        Fetch_Valid_IF,
    output logic        Flush_IF_ID,
    output logic        Redirect_Pending
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending;

    logic        w_redir;
    logic        w_advance;
    logic [31:0] w_sel_dest;
    logic [31:0] w_target;

    // Rst_n gates the combinational outputs so nothing looks valid or
    // flushing while reset is held, whatever the inputs are doing.
    assign w_redir    = Rst_n & (Branch_Taken_ID | Jump_ID) & ~Stall_IF;
    assign w_advance  = Imem_Ready_IF & ~Stall_IF;
    assign w_sel_dest = Branch_Taken_ID ? Branch_Dest_ID : Jump_Dest_ID;
    assign w_target   = w_sel_dest & 32'hFFFF_FFFC;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_pending <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_redir && w_advance) begin
                        r_pc <= w_target;
                    end else if (w_redir) begin
                        r_pending <= w_target;
                        r_state   <= ST_PEND;
                    end else if (w_advance) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                ST_PEND: begin
                    // The word returned now belongs to the old path and is
                    // dropped. A redirect arriving in the same cycle is newer
                    // than the parked one, so it is the one taken.
                    if (w_advance) begin
                        r_pc    <= w_redir ? w_target : r_pending;
                        r_state <= ST_RUN;
                    end else if (w_redir) begin
                        r_pending <= w_target;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign PC_IF            = r_pc;
    assign PC_Plus_4_IF     = r_pc + 32'd4;
    assign Flush_IF_ID      = w_redir;
    assign Fetch_Valid_IF   = Rst_n & Imem_Ready_IF & (r_state == ST_RUN) & ~w_redir;
    assign Redirect_Pending = (r_state == ST_PEND);

endmodule

// File: doc/if_pc_sequencer.md
Name: if_pc_sequencer

Overview:
- Fetch-side consumer of the branch/jump destinations computed in the ID stage.
- Holds the architectural fetch PC and selects the next PC: sequential PC+4, a branch target or a jump target.
- Squashes the wrong-path instruction entering IF/ID.
- Holds a redirect as pending when instruction memory is not ready, so no redirect is lost under memory wait states.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0.

Ports:
Clk  input  1  single clock, rising edge.
Rst_n  input  1  asynchronous, active-low reset.
Stall_IF  input  1  hazard unit hold; PC and pipeline registers freeze.
Imem_Ready_IF  input  1  instruction memory returns the word at PC_IF this cycle.
Branch_Taken_ID  input  1  branch in ID resolved taken.
Branch_Dest_ID  input  32  branch target from the ID-stage adder.
Jump_ID  input  1  jump in ID.
Jump_Dest_ID  input  32  jump target.
PC_IF  output  32  current fetch address (registered).
PC_Plus_4_IF  output  32  PC_IF + 4, forwarded to IF/ID.
Fetch_Valid_IF  output  1  the instruction word at PC_IF is on the correct path and may be latched into IF/ID.
Flush_IF_ID  output  1  IF/ID loads a bubble at the next edge.
Redirect_Pending  output  1  high while in state PEND (debug/perf).

Behaviour:
- Reset (Rst_n=0, async): PC_IF=RESET_PC, state=RUN, pending target=0. Fetch_Valid_IF=0, Flush_IF_ID=0, Redirect_Pending=0 while reset is held.
- Redirect request:
  - redir = (Branch_Taken_ID | Jump_ID) & ~Stall_IF.
  - Redirect inputs are ignored while Stall_IF=1; ID holds and re-presents them.
  - If both Branch_Taken_ID and Jump_ID are asserted, the branch wins.
  - Target = selected destination with bits [1:0] forced to 00.
- advance = Imem_Ready_IF & ~Stall_IF.
- PC_Plus_4_IF = PC_IF + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). Combinational from PC_IF.
- FSM states RUN and PEND. All transitions occur on the rising edge of Clk.
- RUN:
  - redir & advance: PC_IF <= target; stay RUN.
  - redir & ~advance: pending <= target; go to PEND; PC_IF unchanged.
  - ~redir & advance: PC_IF <= PC_IF + 4.
  - Otherwise: hold.
- PEND:
  - Imem_Ready_IF & ~Stall_IF: the returned word is wrong-path and is discarded. PC_IF <= pending; go to RUN.
  - redir (latest wins): pending <= new target; stay PEND.
  - Otherwise: hold.
- Flush_IF_ID = redir, in either state, combinational. Asserted for exactly one cycle per accepted redirect.
- Fetch_Valid_IF = Imem_Ready_IF & (state==RUN) & ~redir, combinational. It is always 0 in PEND.
- Latency:
  - Redirect with memory ready: target appears on PC_IF 1 cycle after the redirect cycle.
  - Pending redirect: target appears 1 cycle after the cycle in which Imem_Ready_IF=1 and Stall_IF=0.
- Stall_IF=1 in any state: PC_IF, state and pending are all held. Fetch_Valid_IF still follows its equation; IF/ID gating on the stall belongs to the IF/ID register.
- Reset asserted mid-PEND: the pending redirect is abandoned and PC_IF=RESET_PC immediately.
- No X-propagation: pending target is reset, so Redirect_Pending and PC_IF are always defined.

Test Plan:
- Reset: Rst_n low mid-cycle with RESET_PC=32'h0040_0000 -> PC_IF=32'h0040_0000 immediately; after release with Imem_Ready_IF=1, PC_IF steps 0x00400004, 0x00400008 and Fetch_Valid_IF=1 each cycle.
- Taken branch, memory ready: PC_IF=0x100, Branch_Taken_ID=1, Branch_Dest_ID=0x1F0 -> Flush_IF_ID=1 and Fetch_Valid_IF=0 that cycle; next cycle PC_IF=0x1F0 and Flush_IF_ID=0.
- Redirect during memory wait:
  - Stimulus: PC_IF=0x200, Imem_Ready_IF=0, Jump_ID=1, Jump_Dest_ID=0x803.
  - Required: Flush_IF_ID=1 for that cycle; Redirect_Pending=1 from the next cycle; PC_IF holds 0x200 for three wait cycles.
  - Then Imem_Ready_IF=1: Fetch_Valid_IF=0 that cycle, and PC_IF=0x800 the following cycle.
- Stall masking: Stall_IF=1 with Branch_Taken_ID=1, Branch_Dest_ID=0x40 for two cycles -> no Flush_IF_ID, PC_IF held; drop Stall_IF -> redirect accepted, PC_IF=0x40 next cycle.
- Priority and wrap: Branch_Taken_ID=1 (dest 0x10) and Jump_ID=1 (dest 0x20) together -> PC_IF=0x10. Separately, PC_IF=0xFFFF_FFFC with no redirect -> PC_Plus_4_IF=0, and PC_IF=0 next cycle.
- Reset in PEND: enter PEND with pending=0x900, assert Rst_n=0 -> Redirect_Pending=0 and PC_IF=RESET_PC asynchronously; after release, the fetch never visits 0x900.
